// File: rtl/onewire_pkg.sv
// rtl/onewire_pkg.sv - 1-Wire command codes, slot timing and responder state encoding
package onewire_pkg;

  localparam logic [7:0] SKIP_ROM  = 8'hCC;
  localparam logic [7:0] WRITE_SCR = 8'h4E;
  localparam logic [7:0] CONVERT_T = 8'h44;
  localparam logic [7:0] READ_SCR  = 8'hBE;

  localparam int RESET_US     = 480;
  localparam int PRES_WAIT_US = 30;
  localparam int PRES_US      = 120;
  localparam int SLOT_US      = 30;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_PRES_WAIT  = 3'd1;
  localparam logic [2:0] ST_PRES_DRIVE = 3'd2;
  localparam logic [2:0] ST_ROM_CMD    = 3'd3;
  localparam logic [2:0] ST_FUNC_CMD   = 3'd4;
  localparam logic [2:0] ST_WR_SCR     = 3'd5;
  localparam logic [2:0] ST_RD_SCR     = 3'd6;
  localparam logic [2:0] ST_CONV_POLL  = 3'd7;

  // Dallas CRC8 (x^8+x^5+x^4+1), one LSB-first bit per call
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[0] ^ b;
    return {1'b0, crc[7:1]} ^ (fb ? 8'h8C : 8'h00);
  endfunction

endpackage

// File: rtl/onewire_crc8.sv
// rtl/onewire_crc8.sv - serial Dallas CRC8 accumulator
module onewire_crc8
  import onewire_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr)
      crc_d = 8'h00;
    else if (en)
      crc_d = crc8_step(crc_q, bit_i);
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= 8'h00;
    else     crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/ds18b20_slave_model.sv
// rtl/ds18b20_slave_model.sv - single DS18B20 responder on an open-drain 1-Wire DQ net
module ds18b20_slave_model
  import onewire_pkg::*;
#(
  parameter int CLK_PER_US = 50,
  parameter int CONV_US    = 750000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dq_i,
  output logic        dq_pull,
  input  logic [15:0] temp_i,
  output logic [7:0]  cmd_o,
  output logic        cmd_strb,
  output logic        converting,
  output logic [7:0]  th_o,
  output logic [7:0]  tl_o,
  output logic [7:0]  cfg_o
);

  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  logic [2:0]    dq_s_q, dq_s_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [9:0]    low_us_q, low_us_d;
  logic [2:0]    state_q, state_d;
  logic [6:0]    tmr_q, tmr_d;
  logic          slot_act_q, slot_act_d;
  logic          drive_q, drive_d;
  logic          dq_pull_q, dq_pull_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [3:0]    byte_idx_q, byte_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          cmd_strb_q, cmd_strb_d;
  logic          converting_q, converting_d;
  logic [31:0]   conv_cnt_q, conv_cnt_d;
  logic [15:0]   temp_q, temp_d;
  logic [7:0]    th_q, th_d, tl_q, tl_d, cfg_q, cfg_d;

  logic       tick, fall, rise, rd_bit, crc_clr, crc_en;
  logic [7:0] rd_byte, rx_byte, crc_val;

  onewire_crc8 u_crc (
    .clk   (clk),
    .rst   (rst),
    .clr   (crc_clr),
    .en    (crc_en),
    .bit_i (rd_bit),
    .crc_o (crc_val)
  );

  assign tick = (pre_q == PW'(CLK_PER_US - 1));
  assign fall = dq_s_q[2] & ~dq_s_q[1];
  assign rise = ~dq_s_q[2] & dq_s_q[1];

  always_comb begin
    case (byte_idx_q)
      4'd0:    rd_byte = temp_q[7:0];
      4'd1:    rd_byte = temp_q[15:8];
      4'd2:    rd_byte = th_q;
      4'd3:    rd_byte = tl_q;
      4'd4:    rd_byte = cfg_q;
      4'd5:    rd_byte = 8'hFF;
      4'd6:    rd_byte = 8'h0C;
      4'd7:    rd_byte = 8'h10;
      4'd8:    rd_byte = crc_val;
      default: rd_byte = 8'hFF;
    endcase
    rd_bit = (state_q == ST_CONV_POLL) ? ~converting_q : rd_byte[bit_idx_q];
  end

  always_comb begin
    dq_s_d       = {dq_s_q[1:0], dq_i};
    pre_d        = tick ? '0 : pre_q + 1'b1;
    low_us_d     = low_us_q;
    state_d      = state_q;
    tmr_d        = tmr_q;
    slot_act_d   = slot_act_q;
    drive_d      = drive_q;
    bit_idx_d    = bit_idx_q;
    byte_idx_d   = byte_idx_q;
    shreg_d      = shreg_q;
    cmd_d        = cmd_q;
    cmd_strb_d   = 1'b0;
    converting_d = converting_q;
    conv_cnt_d   = conv_cnt_q;
    temp_d       = temp_q;
    th_d         = th_q;
    tl_d         = tl_q;
    cfg_d        = cfg_q;
    crc_clr      = 1'b0;
    crc_en       = 1'b0;
    rx_byte      = {dq_s_q[1], shreg_q[7:1]};

    if (rise)
      low_us_d = 10'd0;
    else if (!dq_s_q[1] && tick && low_us_q != 10'd1023)
      low_us_d = low_us_q + 10'd1;

    // Conversion runs independently of the bus FSM; only rst stops it
    if (converting_q && tick) begin
      if (conv_cnt_q == 32'(CONV_US - 1)) begin
        converting_d = 1'b0;
        temp_d       = temp_i;
      end else begin
        conv_cnt_d = conv_cnt_q + 32'd1;
      end
    end

    case (state_q)
      ST_PRES_WAIT: if (tick) begin
        if (tmr_q == 7'(PRES_WAIT_US - 1)) begin
          state_d = ST_PRES_DRIVE;
          tmr_d   = 7'd0;
        end else tmr_d = tmr_q + 7'd1;
      end
      ST_PRES_DRIVE: if (tick) begin
        if (tmr_q == 7'(PRES_US - 1)) begin
          state_d = ST_ROM_CMD;
          tmr_d   = 7'd0;
        end else tmr_d = tmr_q + 7'd1;
      end
      ST_ROM_CMD, ST_FUNC_CMD, ST_WR_SCR: begin
        if (fall) begin
          slot_act_d = 1'b1;
          tmr_d      = 7'd0;
        end else if (slot_act_q && tick) begin
          if (tmr_q == 7'(SLOT_US - 1)) begin
            slot_act_d = 1'b0;
            shreg_d    = rx_byte;
            bit_idx_d  = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              if (state_q == ST_ROM_CMD) begin
                state_d = (rx_byte == SKIP_ROM) ? ST_FUNC_CMD : ST_IDLE;
              end else if (state_q == ST_FUNC_CMD) begin
                cmd_d      = rx_byte;
                cmd_strb_d = 1'b1;
                case (rx_byte)
                  WRITE_SCR: begin
                    state_d    = ST_WR_SCR;
                    byte_idx_d = 4'd0;
                  end
                  CONVERT_T: begin
                    state_d      = ST_CONV_POLL;
                    converting_d = 1'b1;
                    conv_cnt_d   = 32'd0;
                  end
                  READ_SCR: begin
                    state_d    = ST_RD_SCR;
                    byte_idx_d = 4'd0;
                    crc_clr    = 1'b1;
                  end
                  default: state_d = ST_IDLE;
                endcase
              end else begin
                byte_idx_d = byte_idx_q + 4'd1;
                case (byte_idx_q)
                  4'd0:    th_d = rx_byte;
                  4'd1:    tl_d = rx_byte;
                  default: begin
                    cfg_d   = rx_byte;
                    state_d = ST_IDLE;
                  end
                endcase
              end
            end
          end else tmr_d = tmr_q + 7'd1;
        end
      end
      ST_RD_SCR, ST_CONV_POLL: begin
        if (fall) begin
          if (!rd_bit) begin
            drive_d = 1'b1;
            tmr_d   = 7'd0;
          end
          // Index 9 means the scratchpad is exhausted: idle ones, no CRC update
          if (state_q == ST_RD_SCR && byte_idx_q != 4'd9) begin
            crc_en    = (byte_idx_q < 4'd8);
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) byte_idx_d = byte_idx_q + 4'd1;
          end
        end else if (drive_q && tick) begin
          if (tmr_q == 7'(SLOT_US - 1)) drive_d = 1'b0;
          else                          tmr_d   = tmr_q + 7'd1;
        end
      end
      default: ;
    endcase

    if (rise && low_us_q >= 10'(RESET_US)) begin
      state_d    = ST_PRES_WAIT;
      tmr_d      = 7'd0;
      bit_idx_d  = 3'd0;
      byte_idx_d = 4'd0;
      slot_act_d = 1'b0;
      drive_d    = 1'b0;
    end

    dq_pull_d = (state_d == ST_PRES_DRIVE) || drive_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dq_s_q       <= 3'b111;
      pre_q        <= '0;
      low_us_q     <= 10'd0;
      state_q      <= ST_IDLE;
      tmr_q        <= 7'd0;
      slot_act_q   <= 1'b0;
      drive_q      <= 1'b0;
      dq_pull_q    <= 1'b0;
      bit_idx_q    <= 3'd0;
      byte_idx_q   <= 4'd0;
      shreg_q      <= 8'h00;
      cmd_q        <= 8'h00;
      cmd_strb_q   <= 1'b0;
      converting_q <= 1'b0;
      conv_cnt_q   <= 32'd0;
      temp_q       <= 16'h0550;
      th_q         <= 8'h4B;
      tl_q         <= 8'h46;
      cfg_q        <= 8'h7F;
    end else begin
      dq_s_q       <= dq_s_d;
      pre_q        <= pre_d;
      low_us_q     <= low_us_d;
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      slot_act_q   <= slot_act_d;
      drive_q      <= drive_d;
      dq_pull_q    <= dq_pull_d;
      bit_idx_q    <= bit_idx_d;
      byte_idx_q   <= byte_idx_d;
      shreg_q      <= shreg_d;
      cmd_q        <= cmd_d;
      cmd_strb_q   <= cmd_strb_d;
      converting_q <= converting_d;
      conv_cnt_q   <= conv_cnt_d;
      temp_q       <= temp_d;
      th_q         <= th_d;
      tl_q         <= tl_d;
      cfg_q        <= cfg_d;
    end
  end

  assign dq_pull    = dq_pull_q;
  assign cmd_o      = cmd_q;
  assign cmd_strb   = cmd_strb_q;
  assign converting = converting_q;
  assign th_o       = th_q;
  assign tl_o       = tl_q;
  assign cfg_o      = cfg_q;

endmodule

// File: tb/tb_ds18b20_slave_model.sv
// tb/tb_ds18b20_slave_model.sv - 1-Wire master-side bench for the DS18B20 responder
module tb_ds18b20_slave_model;

  localparam int US   = 2;
  localparam int CONV = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_pull = 1'b0;
  logic [15:0] temp_i = 16'h0000;
  logic        dq_pull, cmd_strb, converting;
  logic [7:0]  cmd_o, th_o, tl_o, cfg_o;
  wire         dq_line = ~(m_pull | dq_pull);

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, pull_cyc = 0, strb_cnt = 0, conv_start = -1;

  logic [15:0] m_temp = 16'h0550;
  logic [7:0]  m_th = 8'h4B, m_tl = 8'h46, m_cfg = 8'h7F;

  always #5 clk = ~clk;

  ds18b20_slave_model #(.CLK_PER_US(US), .CONV_US(CONV)) dut (
    .clk        (clk),
    .rst        (rst),
    .dq_i       (dq_line),
    .dq_pull    (dq_pull),
    .temp_i     (temp_i),
    .cmd_o      (cmd_o),
    .cmd_strb   (cmd_strb),
    .converting (converting),
    .th_o       (th_o),
    .tl_o       (tl_o),
    .cfg_o      (cfg_o)
  );

  always @(negedge clk) begin
    cyc++;
    if (dq_pull) pull_cyc++;
    if (cmd_strb) begin
      strb_cnt++;
      if (cmd_o == 8'h44) conv_start = cyc;
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] crc_ref(input logic [7:0] bytes [9], input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 8; k++)
        c = (c[0] ^ bytes[i][k]) ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    return c;
  endfunction

  task automatic wait_us(input int n);
    repeat (n * US) @(negedge clk);
  endtask

  task automatic bus_reset(output bit pres, output int rise_cyc, output int width_cyc,
                           output bit low_drive);
    pres = 1'b0; rise_cyc = 0; width_cyc = 0; low_drive = 1'b0;
    @(negedge clk);
    m_pull = 1'b1;
    for (int i = 0; i < 500 * US; i++) begin
      @(negedge clk);
      if (i > 60 * US && dq_pull) low_drive = 1'b1;
    end
    m_pull = 1'b0;
    for (int i = 0; i < 100 * US && !pres; i++) begin
      @(negedge clk);
      rise_cyc++;
      if (dq_pull) pres = 1'b1;
    end
    if (pres)
      while (dq_pull && width_cyc < 200 * US) begin
        @(negedge clk);
        width_cyc++;
      end
    wait_us(10);
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int k = 0; k < 8; k++) begin
      m_pull = 1'b1;
      wait_us(v[k] ? 6 : 60);
      m_pull = 1'b0;
      wait_us(v[k] ? 59 : 5);
    end
  endtask

  task automatic read_bit(output bit b, output int ts);
    ts = cyc;
    m_pull = 1'b1;
    wait_us(2);
    m_pull = 1'b0;
    wait_us(10);
    b = dq_line;
    wait_us(53);
  endtask

  task automatic read_byte(output logic [7:0] v);
    bit b;
    int ts;
    for (int k = 0; k < 8; k++) begin
      read_bit(b, ts);
      v[k] = b;
    end
  endtask

  task automatic check_scratch(input string tag);
    logic [7:0] exp_b [9];
    logic [7:0] got_b [9];
    bit p, ld;
    int r, w;
    exp_b[0] = m_temp[7:0]; exp_b[1] = m_temp[15:8];
    exp_b[2] = m_th; exp_b[3] = m_tl; exp_b[4] = m_cfg;
    exp_b[5] = 8'hFF; exp_b[6] = 8'h0C; exp_b[7] = 8'h10;
    exp_b[8] = crc_ref(exp_b, 8);
    bus_reset(p, r, w, ld);
    n_cmp++;
    if (p !== 1'b1) begin n_bad++; $display("FAIL %s presence: got %0b want 1", tag, p); end
    write_byte(8'hCC);
    write_byte(8'hBE);
    for (int i = 0; i < 9; i++) begin
      read_byte(got_b[i]);
      n_cmp++;
      if (got_b[i] !== exp_b[i]) begin
        n_bad++;
        $display("FAIL %s byte%0d: got %02h want %02h", tag, i, got_b[i], exp_b[i]);
      end
    end
    n_cmp++;
    if (crc_ref(got_b, 9) !== 8'h00) begin
      n_bad++;
      $display("FAIL %s crc_residue: got %02h want 00", tag, crc_ref(got_b, 9));
    end
  endtask

  task automatic test_reset();
    bit p, ld;
    int r, w;
    n_cmp++; if (dq_pull !== 1'b0)    begin n_bad++; $display("FAIL rst dq_pull: got %0b want 0", dq_pull); end
    n_cmp++; if (cmd_o !== 8'h00)     begin n_bad++; $display("FAIL rst cmd_o: got %02h want 00", cmd_o); end
    n_cmp++; if (cmd_strb !== 1'b0)   begin n_bad++; $display("FAIL rst cmd_strb: got %0b want 0", cmd_strb); end
    n_cmp++; if (converting !== 1'b0) begin n_bad++; $display("FAIL rst converting: got %0b want 0", converting); end
    n_cmp++; if (th_o !== 8'h4B)      begin n_bad++; $display("FAIL rst th_o: got %02h want 4B", th_o); end
    n_cmp++; if (tl_o !== 8'h46)      begin n_bad++; $display("FAIL rst tl_o: got %02h want 46", tl_o); end
    n_cmp++; if (cfg_o !== 8'h7F)     begin n_bad++; $display("FAIL rst cfg_o: got %02h want 7F", cfg_o); end
    bus_reset(p, r, w, ld);
    n_cmp++; if (p !== 1'b1)  begin n_bad++; $display("FAIL presence seen: got %0b want 1", p); end
    n_cmp++; if (ld !== 1'b0) begin n_bad++; $display("FAIL drive_in_reset_low: got %0b want 0", ld); end
    n_cmp++;
    if (r < 29 * US || r > 31 * US + 4) begin
      n_bad++; $display("FAIL presence delay: got %0d cycles want %0d +-%0d", r, 30 * US, US + 4);
    end
    n_cmp++;
    if (w < 119 * US - 2 || w > 121 * US + 2) begin
      n_bad++; $display("FAIL presence width: got %0d cycles want %0d +-%0d", w, 120 * US, US + 2);
    end
  endtask

  task automatic test_mid_read();
    bit p, ld, b;
    int r, w, ts;
    logic [7:0] v;
    bus_reset(p, r, w, ld);
    write_byte(8'hCC);
    write_byte(8'hBE);
    for (int k = 0; k < 3; k++) begin
      read_bit(b, ts);
      n_cmp++;
      if (b !== m_temp[k]) begin n_bad++; $display("FAIL mid bit%0d: got %0b want %0b", k, b, m_temp[k]); end
    end
    bus_reset(p, r, w, ld);
    n_cmp++; if (p !== 1'b1) begin n_bad++; $display("FAIL mid presence: got %0b want 1", p); end
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_byte(v);
    n_cmp++; if (v !== m_temp[7:0])  begin n_bad++; $display("FAIL mid byte0: got %02h want %02h", v, m_temp[7:0]); end
    read_byte(v);
    n_cmp++; if (v !== m_temp[15:8]) begin n_bad++; $display("FAIL mid byte1: got %02h want %02h", v, m_temp[15:8]); end
  endtask

  task automatic test_write();
    bit p, ld;
    int r, w, s0;
    s0 = strb_cnt;
    bus_reset(p, r, w, ld);
    write_byte(8'hCC); write_byte(8'h4E);
    write_byte(8'hFF); write_byte(8'hFF); write_byte(8'h1F);
    m_th = 8'hFF; m_tl = 8'hFF; m_cfg = 8'h1F;
    wait_us(2);
    n_cmp++; if (strb_cnt - s0 !== 1) begin n_bad++; $display("FAIL wr strobes: got %0d want 1", strb_cnt - s0); end
    n_cmp++; if (cmd_o !== 8'h4E)  begin n_bad++; $display("FAIL wr cmd_o: got %02h want 4E", cmd_o); end
    n_cmp++; if (th_o !== m_th)    begin n_bad++; $display("FAIL wr th_o: got %02h want %02h", th_o, m_th); end
    n_cmp++; if (tl_o !== m_tl)    begin n_bad++; $display("FAIL wr tl_o: got %02h want %02h", tl_o, m_tl); end
    n_cmp++; if (cfg_o !== m_cfg)  begin n_bad++; $display("FAIL wr cfg_o: got %02h want %02h", cfg_o, m_cfg); end
  endtask

  task automatic test_convert();
    bit p, ld, b, done;
    int r, w, ts, el, zeros;
    temp_i = 16'h0191;
    conv_start = -1;
    bus_reset(p, r, w, ld);
    write_byte(8'hCC); write_byte(8'h44);
    n_cmp++; if (converting !== 1'b1) begin n_bad++; $display("FAIL conv started: got %0b want 1", converting); end
    n_cmp++; if (cmd_o !== 8'h44)     begin n_bad++; $display("FAIL conv cmd_o: got %02h want 44", cmd_o); end
    done = 1'b0; zeros = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      read_bit(b, ts);
      el = ts - conv_start;
      if (el < (CONV - 3) * US || el > (CONV + 3) * US) begin
        n_cmp++;
        if (b !== (el >= CONV * US)) begin
          n_bad++; $display("FAIL conv poll at %0d cycles: got %0b want %0b", el, b, el >= CONV * US);
        end
      end
      if (b) done = 1'b1; else zeros++;
    end
    m_temp = 16'h0191;
    n_cmp++; if (done !== 1'b1)       begin n_bad++; $display("FAIL conv done seen: got %0b want 1", done); end
    n_cmp++; if (zeros < 1)           begin n_bad++; $display("FAIL conv busy polls: got %0d want >=1", zeros); end
    n_cmp++; if (converting !== 1'b0) begin n_bad++; $display("FAIL conv ended: got %0b want 0", converting); end
  endtask

  task automatic test_bad_rom();
    bit p, ld;
    int r, w, p0;
    logic [7:0] v, c0;
    bus_reset(p, r, w, ld);
    c0 = cmd_o;
    write_byte(8'h33);
    p0 = pull_cyc;
    read_byte(v);
    n_cmp++; if (v !== 8'hFF)          begin n_bad++; $display("FAIL badrom read: got %02h want FF", v); end
    n_cmp++; if (pull_cyc - p0 !== 0)  begin n_bad++; $display("FAIL badrom drive: got %0d cycles want 0", pull_cyc - p0); end
    n_cmp++; if (cmd_o !== c0)         begin n_bad++; $display("FAIL badrom cmd_o: got %02h want %02h", cmd_o, c0); end
    bus_reset(p, r, w, ld);
    n_cmp++; if (p !== 1'b1)           begin n_bad++; $display("FAIL badrom recovery presence: got %0b want 1", p); end
  endtask

  task automatic test_random();
    bit p, ld;
    int r, w;
    logic [7:0] a, b2, c, a2, b3;
    a = 8'($urandom); b2 = 8'($urandom); c = 8'($urandom);
    a2 = 8'($urandom); b3 = 8'($urandom);
    bus_reset(p, r, w, ld);
    write_byte(8'hCC); write_byte(8'h4E);
    write_byte(a); write_byte(b2); write_byte(c);
    bus_reset(p, r, w, ld);
    write_byte(8'hCC); write_byte(8'h4E);
    write_byte(a2); write_byte(b3);
    bus_reset(p, r, w, ld);
    m_th = a2; m_tl = b3; m_cfg = c;
    n_cmp++; if (th_o !== m_th)   begin n_bad++; $display("FAIL rnd partial th_o: got %02h want %02h", th_o, m_th); end
    n_cmp++; if (tl_o !== m_tl)   begin n_bad++; $display("FAIL rnd partial tl_o: got %02h want %02h", tl_o, m_tl); end
    n_cmp++; if (cfg_o !== m_cfg) begin n_bad++; $display("FAIL rnd partial cfg_o: got %02h want %02h", cfg_o, m_cfg); end
    temp_i = 16'($urandom);
    write_byte(8'hCC); write_byte(8'h44);
    m_temp = temp_i;
    check_scratch("rnd");
  endtask

  task automatic test_rst_mid();
    bit p, ld;
    int r, w;
    bus_reset(p, r, w, ld);
    write_byte(8'hCC); write_byte(8'h44);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (converting !== 1'b0) begin n_bad++; $display("FAIL rstmid converting: got %0b want 0", converting); end
    n_cmp++; if (th_o !== 8'h4B)      begin n_bad++; $display("FAIL rstmid th_o: got %02h want 4B", th_o); end
    n_cmp++; if (cfg_o !== 8'h7F)     begin n_bad++; $display("FAIL rstmid cfg_o: got %02h want 7F", cfg_o); end
    n_cmp++; if (cmd_o !== 8'h00)     begin n_bad++; $display("FAIL rstmid cmd_o: got %02h want 00", cmd_o); end
    n_cmp++; if (dq_pull !== 1'b0)    begin n_bad++; $display("FAIL rstmid dq_pull: got %0b want 0", dq_pull); end
    rst = 1'b0;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    test_reset();
    test_mid_read();
    test_write();
    test_convert();
    check_scratch("read");
    test_bad_rom();
    test_random();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
